crack_result_tracker: RTL and testbench

- Sits directly downstream of the hash comparator in the MD5 password-cracking pipeline.
- Holds every guess issued into the hash pipeline in an in-order queue and pairs each comparator result (equal_valid/hashes_equal) with its guess.
- On a match it captures the cracked password and halts the search. It also reports keyspace exhaustion and the number of attempts.

---
 rtl/crack_result_tracker.sv | 172 +++++++++++++++++
 tb/tb_crack_result_tracker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/crack_result_tracker.sv
`default_nettype none
// ============================================================================
// Module      : crack_result_tracker
// Description : Pairs in-order hash comparator results with the guesses that
//               produced them, captures a cracked password, tracks exhaustion.
// Revision    : 1.0 - initial release
// ============================================================================
module crack_result_tracker #(
    parameter int GUESS_W = 64,
    parameter int DEPTH   = 16,
    parameter int ATT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               guess_valid,
    input  logic [GUESS_W-1:0] guess,
    output logic               guess_ready,
    input  logic               space_done,
    input  logic               equal_valid,
    input  logic               hashes_equal,
    output logic               search_active,
    output logic               found,
    output logic               done,
    output logic [GUESS_W-1:0] found_guess,
    output logic [ATT_W-1:0]   attempts,
    output logic               underflow_err
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_search    = 2'd1;
    localparam logic [1:0] c_found     = 2'd2;
    localparam logic [1:0] c_exhausted = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [GUESS_W-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_found;
    logic               r_done;
    logic [GUESS_W-1:0] r_found_guess;
    logic [ATT_W-1:0]   r_attempts;
    logic               r_underflow;
    logic               r_last_issued;

    logic               w_searching;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_match;
    logic               w_exhaust;
    logic               w_start_ok;
    logic [c_cnt_w-1:0] w_count_after;

    assign w_searching = (r_state == c_search);
    assign w_full      = (r_count == c_full_cnt);
    assign w_empty     = (r_count == '0);
    assign w_push      = w_searching && guess_valid && !w_full;
    assign w_pop       = w_searching && equal_valid && !w_empty;
    assign w_match     = w_pop && hashes_equal;
    assign w_start_ok  = start && !w_searching;

    assign w_count_after = r_count + (w_push ? c_cnt_w'(1) : '0)
                                   - (w_pop  ? c_cnt_w'(1) : '0);

    // space_done counts in the same cycle so a coincident final pop still exhausts
    assign w_exhaust = w_searching && !w_match && (r_last_issued || space_done)
                       && (w_count_after == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle, c_found, c_exhausted: begin
                if (start) begin
                    w_state_next = c_search;
                end
            end
            c_search: begin
                if (w_match) begin
                    w_state_next = c_found;
                end else if (w_exhaust) begin
                    w_state_next = c_exhausted;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= guess;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_found       <= 1'b0;
            r_done        <= 1'b0;
            r_found_guess <= '0;
            r_attempts    <= '0;
            r_underflow   <= 1'b0;
            r_last_issued <= 1'b0;
        end else if (w_start_ok) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_found       <= 1'b0;
            r_done        <= 1'b0;
            r_found_guess <= '0;
            r_attempts    <= '0;
            r_last_issued <= 1'b0;
        end else if (w_searching) begin
            if (equal_valid && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_pop && (r_attempts != '1)) begin
                r_attempts <= r_attempts + ATT_W'(1);
            end
            if (w_match) begin
                // flush: anything pushed this cycle is dropped with the rest
                r_found_guess <= r_mem[r_rd_ptr];
                r_found       <= 1'b1;
                r_done        <= 1'b1;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_count       <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                r_count <= w_count_after;
                if (space_done) begin
                    r_last_issued <= 1'b1;
                end
                if (w_exhaust) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign guess_ready   = w_searching && !w_full;
    assign search_active = w_searching;
    assign found         = r_found;
    assign done          = r_done;
    assign found_guess   = r_found_guess;
    assign attempts      = r_attempts;
    assign underflow_err = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_crack_result_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_crack_result_tracker
// Description : Directed and randomized bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crack_result_tracker;

    logic        clk = 1'b0;
    logic        reset, start, guess_valid, space_done, equal_valid, hashes_equal;
    logic [63:0] guess;
    logic        guess_ready, search_active, found, done, underflow_err;
    logic [63:0] found_guess;
    logic [31:0] attempts;

    always #5 clk = ~clk;

    crack_result_tracker #(.GUESS_W(64), .DEPTH(16), .ATT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .guess_valid(guess_valid),
        .guess(guess), .guess_ready(guess_ready), .space_done(space_done),
        .equal_valid(equal_valid), .hashes_equal(hashes_equal),
        .search_active(search_active), .found(found), .done(done),
        .found_guess(found_guess), .attempts(attempts),
        .underflow_err(underflow_err)
    );

    // model: 0 idle, 1 search, 2 found, 3 exhausted
    int          m_state;
    logic [63:0] m_q [$];
    bit          m_found, m_done, m_uf, m_last;
    logic [63:0] m_fg;
    logic [31:0] m_att;

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, st, gv, input logic [63:0] g,
                              input bit sd, ev, he);
        logic [63:0] head;
        bit          push;
        if (rst) begin
            m_state = 0; m_q.delete(); m_found = 0; m_done = 0; m_uf = 0;
            m_last = 0; m_fg = '0; m_att = '0;
        end else if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_q.delete(); m_found = 0; m_done = 0;
                m_last = 0; m_fg = '0; m_att = '0;
            end
        end else begin
            push = gv && (m_q.size() < 16);
            if (ev && m_q.size() == 0) m_uf = 1;
            if (ev && m_q.size() > 0) begin
                head = m_q.pop_front();
                if (m_att != 32'hFFFF_FFFF) m_att++;
                if (he) begin
                    m_fg = head; m_found = 1; m_done = 1; m_q.delete(); m_state = 2;
                    return;
                end
            end
            if (push) m_q.push_back(g);
            if (sd) m_last = 1;
            if (m_last && m_q.size() == 0) begin
                m_state = 3; m_done = 1;
            end
        end
    endtask

    task automatic cyc(input bit rst, st, gv, input logic [63:0] g,
                       input bit sd, ev, he);
        reset = rst; start = st; guess_valid = gv; guess = g;
        space_done = sd; equal_valid = ev; hashes_equal = he;
        @(posedge clk);
        model_step(rst, st, gv, g, sd, ev, he);
        #1;
        check("search_active", 64'(search_active), 64'(m_state == 1));
        check("guess_ready", 64'(guess_ready), 64'(m_state == 1 && m_q.size() < 16));
        check("found", 64'(found), 64'(m_found));
        check("done", 64'(done), 64'(m_done));
        check("found_guess", found_guess, m_fg);
        check("attempts", 64'(attempts), 64'(m_att));
        check("underflow_err", 64'(underflow_err), 64'(m_uf));
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        bit          r_st, r_gv, r_sd, r_ev, r_he, r_rst;
        logic [63:0] r_g;

        // reset
        cyc(1, 0, 0, '0, 0, 0, 0);
        cyc(1, 0, 0, '0, 0, 0, 0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_active", 64'(search_active), 64'd0);

        // basic match on the third guess
        cyc(0, 1, 0, '0, 0, 0, 0);
        cyc(0, 0, 1, 64'h41, 0, 0, 0);
        cyc(0, 0, 1, 64'h42, 0, 0, 0);
        cyc(0, 0, 1, 64'h43, 0, 0, 0);
        idle_cyc(); idle_cyc(); idle_cyc();
        cyc(0, 0, 0, '0, 0, 1, 0);
        cyc(0, 0, 0, '0, 0, 1, 0);
        check("pre_match_found", 64'(found), 64'd0);
        cyc(0, 0, 0, '0, 0, 1, 1);
        check("t1_found", 64'(found), 64'd1);
        check("t1_done", 64'(done), 64'd1);
        check("t1_guess", found_guess, 64'h43);
        check("t1_attempts", 64'(attempts), 64'd3);
        cyc(0, 0, 0, '0, 0, 1, 1);
        check("t1_hold_attempts", 64'(attempts), 64'd3);

        // exhaustion with space_done on the last push
        cyc(0, 1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 64'h100 + 64'(i), (i == 3), 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0, 0, 1, 0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_found", 64'(found), 64'd0);
        check("t2_attempts", 64'(attempts), 64'd4);
        check("t2_active", 64'(search_active), 64'd0);

        // fill to DEPTH, reject the 17th, then wrap with push/pop pairs
        cyc(0, 1, 0, '0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) cyc(0, 0, 1, 64'(i), 0, 0, 0);
        check("t3_full_ready", 64'(guess_ready), 64'd0);
        cyc(0, 0, 1, 64'd99, 0, 0, 0);
        cyc(0, 0, 1, 64'd98, 0, 1, 0);
        check("t3_attempts1", 64'(attempts), 64'd1);
        for (int j = 2; j <= 40; j++) cyc(0, 0, 1, 64'(15 + j), 0, 1, (j == 40));
        check("t3_wrap_guess", found_guess, 64'd40);
        check("t3_wrap_attempts", 64'(attempts), 64'd40);

        // underflow, sticky across start
        cyc(0, 1, 0, '0, 0, 0, 0);
        cyc(0, 0, 0, '0, 0, 1, 0);
        check("t4_underflow", 64'(underflow_err), 64'd1);
        check("t4_attempts", 64'(attempts), 64'd0);
        cyc(0, 0, 0, '0, 1, 0, 0);
        check("t4_exhausted", 64'(done), 64'd1);
        cyc(0, 1, 0, '0, 0, 0, 0);
        check("t4_sticky", 64'(underflow_err), 64'd1);

        // reset mid-search with 5 in flight
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 64'h200 + 64'(i), 0, 0, 0);
        cyc(1, 0, 0, '0, 0, 0, 0);
        check("t5_active", 64'(search_active), 64'd0);
        check("t5_underflow", 64'(underflow_err), 64'd0);
        cyc(0, 0, 0, '0, 0, 1, 1);
        cyc(0, 0, 0, '0, 0, 1, 0);
        check("t5_ignored_att", 64'(attempts), 64'd0);
        check("t5_ignored_found", 64'(found), 64'd0);

        // restart after FOUND, new match on 0x7A
        cyc(0, 1, 0, '0, 0, 0, 0);
        cyc(0, 0, 1, 64'h55, 0, 0, 0);
        cyc(0, 0, 0, '0, 0, 1, 1);
        cyc(0, 1, 0, '0, 0, 0, 0);
        check("t6_found", 64'(found), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_attempts", 64'(attempts), 64'd0);
        check("t6_active", 64'(search_active), 64'd1);
        cyc(0, 0, 1, 64'h11, 0, 0, 0);
        cyc(0, 0, 1, 64'h7A, 0, 1, 0);
        cyc(0, 0, 0, '0, 0, 1, 1);
        check("t6_guess", found_guess, 64'h7A);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r_st  = (m_state != 1) && ($urandom_range(0, 3) == 0);
            r_gv  = ($urandom_range(0, 1) == 1);
            r_g   = {$urandom, $urandom};
            r_ev  = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0)
                                     : ($urandom_range(0, 15) == 0);
            r_he  = ($urandom_range(0, 19) == 0);
            r_sd  = ($urandom_range(0, 29) == 0);
            r_rst = ($urandom_range(0, 199) == 0);
            cyc(r_rst, r_st, r_gv, r_g, r_sd, r_ev, r_he);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
